// File: rtl/md5_digest_checker.sv
// md5_digest_checker
//
// Terminal stage of the hash-breaker pipeline. Each cycle it can take one
// finished 64-round MD5 candidate, add the MD5 initial values to form the
// final digest, and compare that digest against a host-loaded target. It
// counts the candidates it checks. On the first match after an arm it latches
// the winning message block and its index, and it holds them until the host
// acknowledges.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   arm             single-cycle request: load target, clear count, search
//   target          128-bit digest to find, {A,B,C,D} with A in [127:96]
//   in_valid        a_in..d_in and m_in carry a candidate this cycle
//   a_in..d_in      final round state words before IV addition
//   m_in            512-bit message block of the candidate
//   ack             host has read the result; release FOUND
//   busy            high while searching (ARMED)
//   found           high while a match is held (FOUND)
//   match_msg       message block of the matching candidate
//   match_index     0-based index of the matching candidate since last arm
//   checked_count   candidates compared since last arm, saturating

module md5_digest_checker #(
    parameter int CNT_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [127:0]     target,
    input  logic             in_valid,
    input  logic [31:0]      a_in,
    input  logic [31:0]      b_in,
    input  logic [31:0]      c_in,
    input  logic [31:0]      d_in,
    input  logic [511:0]     m_in,
    input  logic             ack,
    output logic             busy,
    output logic             found,
    output logic [511:0]     match_msg,
    output logic [CNT_W-1:0] match_index,
    output logic [CNT_W-1:0] checked_count
);

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        FOUND
    } state_t;

    state_t state;
    state_t next_state;

    logic         s_valid;
    logic [31:0]  s_a;
    logic [31:0]  s_b;
    logic [31:0]  s_c;
    logic [31:0]  s_d;
    logic [511:0] s_msg;
    logic [127:0] target_reg;

    logic hit;
    logic take_arm;
    logic count_en;
    logic capture;

    // Stage 2: the finished digest in stage 1 is compared against the target.
    assign hit = s_valid && ({s_a, s_b, s_c, s_d} == target_reg);

    // State register for the search FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. In ARMED an arm takes priority over
    // whatever sits in stage 1, because a re-arm throws that candidate away.
    // In FOUND only ack matters; a simultaneous arm is dropped.
    always_comb begin
        next_state = state;
        take_arm   = 1'b0;
        count_en   = 1'b0;
        capture    = 1'b0;
        busy       = 1'b0;
        found      = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    take_arm   = 1'b1;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                busy = 1'b1;
                if (arm) begin
                    take_arm = 1'b1;
                end else if (s_valid) begin
                    count_en = 1'b1;
                    if (hit) begin
                        capture    = 1'b1;
                        next_state = FOUND;
                    end
                end
            end
            FOUND: begin
                found = 1'b1;
                if (ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Stage 1: add the MD5 initial values, modulo 2^32. It runs in every
    // state. Anything arriving on the same edge as an accepted arm is
    // invalidated so that it is neither compared nor counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_a     <= '0;
            s_b     <= '0;
            s_c     <= '0;
            s_d     <= '0;
            s_msg   <= '0;
        end else begin
            s_valid <= in_valid && !take_arm;
            s_a     <= a_in + IV_A;
            s_b     <= b_in + IV_B;
            s_c     <= c_in + IV_C;
            s_d     <= d_in + IV_D;
            s_msg   <= m_in;
        end
    end

    // Target, candidate counter and match capture. The counter saturates
    // rather than wrapping, so a very long search never reports a small
    // count. The match index is the count before the matching candidate
    // adds itself, which makes it 0-based.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_reg    <= '0;
            checked_count <= '0;
            match_msg     <= '0;
            match_index   <= '0;
        end else begin
            if (take_arm) begin
                target_reg    <= target;
                checked_count <= '0;
            end else if (count_en && (checked_count != CNT_MAX)) begin
                checked_count <= checked_count + CNT_ONE;
            end
            if (capture) begin
                match_msg   <= s_msg;
                match_index <= checked_count;
            end
        end
    end

endmodule

// File: tb/tb_md5_digest_checker.sv
// Self-checking bench for md5_digest_checker. A main instance uses the
// default 48-bit counter. A second instance with a 4-bit counter shares
// every input and is examined for saturation.

module tb_md5_digest_checker;

    localparam int CNT_W = 48;
    localparam int SAT_W = 4;

    localparam logic [127:0] T_IV   = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [127:0] T_WRAP = {32'h00000000, 32'hefcdab89, 32'h98badcfd, 32'h00325476};

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic             ack;
    logic             in_valid;
    logic [127:0]     target;
    logic [31:0]      a_in;
    logic [31:0]      b_in;
    logic [31:0]      c_in;
    logic [31:0]      d_in;
    logic [511:0]     m_in;

    logic             busy;
    logic             found;
    logic [511:0]     match_msg;
    logic [CNT_W-1:0] match_index;
    logic [CNT_W-1:0] checked_count;

    logic             sat_busy;
    logic             sat_found;
    logic [511:0]     sat_msg;
    logic [SAT_W-1:0] sat_index;
    logic [SAT_W-1:0] sat_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    typedef struct {
        logic [511:0]     msg;
        logic [CNT_W-1:0] idx;
        int               cyc;
    } match_t;

    match_t sb_queue[$];
    match_t exp_rec;
    logic   prev_found = 1'b0;

    md5_digest_checker #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .target        (target),
        .in_valid      (in_valid),
        .a_in          (a_in),
        .b_in          (b_in),
        .c_in          (c_in),
        .d_in          (d_in),
        .m_in          (m_in),
        .ack           (ack),
        .busy          (busy),
        .found         (found),
        .match_msg     (match_msg),
        .match_index   (match_index),
        .checked_count (checked_count)
    );

    md5_digest_checker #(.CNT_W(SAT_W)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .arm           (arm),
        .target        (target),
        .in_valid      (in_valid),
        .a_in          (a_in),
        .b_in          (b_in),
        .c_in          (c_in),
        .d_in          (d_in),
        .m_in          (m_in),
        .ack           (ack),
        .busy          (sat_busy),
        .found         (sat_found),
        .match_msg     (sat_msg),
        .match_index   (sat_index),
        .checked_count (sat_count)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on the
    // falling edge, well away from the rising edge the design uses.
    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp match latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs and waits for the next falling edge. When
    // the bench knows this candidate must produce the reported match, it
    // pushes the expected message, index and the cycle in which found
    // should first be seen (two rising edges later).
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 input logic [511:0] m, input logic do_arm,
                                 input logic do_ack, input logic [127:0] tgt,
                                 input logic push_hit, input logic [CNT_W-1:0] hit_idx);
        match_t rec;
        in_valid = v;
        a_in     = a;
        b_in     = b;
        c_in     = c;
        d_in     = d;
        m_in     = m;
        arm      = do_arm;
        ack      = do_ack;
        target   = tgt;
        if (push_hit) begin
            rec.msg = m;
            rec.idx = hit_idx;
            rec.cyc = cyc + 2;
            sb_queue.push_back(rec);
        end
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0, 1'b0, 128'h0, 1'b0, '0);
        end
    endtask

    task automatic armWith(input logic [127:0] tgt);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b1, 1'b0, tgt, 1'b0, '0);
    endtask

    task automatic ackPulse();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0, 1'b1, 128'h0, 1'b0, '0);
    endtask

    task automatic missCand(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 32'h1, 32'h1, 32'h1, 32'h1, 512'h1, 1'b0, 1'b0, 128'h0, 1'b0, '0);
        end
    endtask

    // Scoreboard side: on each rising edge of found, pop the expected match
    // and compare the latched message, index and arrival cycle.
    always @(negedge clk) begin
        if (!rst && found && !prev_found) begin
            if (sb_queue.size() == 0) begin
                checkOutput("unexpected_match", 512'd1, 512'd0);
            end else begin
                exp_rec = sb_queue.pop_front();
                checkOutput("sb_match_msg", match_msg, exp_rec.msg);
                checkOutput("sb_match_index", match_index, exp_rec.idx);
                checkOutput("sb_match_latency", cyc, exp_rec.cyc);
            end
        end
        prev_found <= found;
    end

    initial begin
        rst      = 1'b1;
        arm      = 1'b0;
        ack      = 1'b0;
        in_valid = 1'b0;
        target   = '0;
        a_in     = '0;
        b_in     = '0;
        c_in     = '0;
        d_in     = '0;
        m_in     = '0;

        // Reset state.
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_found", found, 0);
        checkOutput("reset_msg", match_msg, 0);
        checkOutput("reset_index", match_index, 0);
        checkOutput("reset_count", checked_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while searching with in_valid toggling.
        armWith(T_IV);
        missCand(1);
        idleCycles(1);
        missCand(2);
        checkOutput("pre_reset_count", checked_count, 2);
        checkOutput("pre_reset_busy", busy, 1);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_found", found, 0);
        checkOutput("async_rst_count", checked_count, 0);
        checkOutput("async_rst_sat_count", sat_count, 0);
        @(negedge clk);
        rst = 1'b0;
        // These would match the cleared all-zero target if they were compared.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h98badcff, 32'h10325477, 32'h67452302, 32'hefcdab8a,
                          512'h5, 1'b0, 1'b0, 128'h0, 1'b0, '0);
        end
        idleCycles(1);
        checkOutput("post_rst_count", checked_count, 0);
        checkOutput("post_rst_found", found, 0);
        checkOutput("post_rst_busy", busy, 0);

        // IV-only match: miss, hit A5, hit B6 (lost because already found).
        armWith(T_IV);
        missCand(1);
        applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 512'hA5, 1'b0, 1'b0, 128'h0, 1'b1, 48'd1);
        applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 512'hB6, 1'b0, 1'b0, 128'h0, 1'b0, '0);
        idleCycles(2);
        checkOutput("iv_found", found, 1);
        checkOutput("iv_busy", busy, 0);
        checkOutput("iv_msg", match_msg, 512'hA5);
        checkOutput("iv_index", match_index, 1);
        checkOutput("iv_count", checked_count, 2);
        missCand(3);
        idleCycles(1);
        checkOutput("iv_count_held", checked_count, 2);
        checkOutput("iv_msg_held", match_msg, 512'hA5);

        // Handshake: arm alone in FOUND is ignored; arm+ack ends in IDLE.
        armWith(T_WRAP);
        checkOutput("hs_arm_ignored_found", found, 1);
        checkOutput("hs_arm_ignored_busy", busy, 0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b1, 1'b1, T_WRAP, 1'b0, '0);
        idleCycles(1);
        checkOutput("hs_ack_found", found, 0);
        checkOutput("hs_ack_busy", busy, 0);
        checkOutput("hs_msg_retained", match_msg, 512'hA5);
        checkOutput("hs_index_retained", match_index, 1);
        ackPulse();
        checkOutput("hs_idle_ack_found", found, 0);
        checkOutput("hs_idle_ack_busy", busy, 0);
        armWith(T_WRAP);
        checkOutput("hs_rearm_busy", busy, 1);
        checkOutput("hs_rearm_count", checked_count, 0);

        // Wrap arithmetic: 0x98badcff + 0x67452301 drops its carry to zero.
        applyStimulus(1'b1, 32'h98badcfe, 32'h0, 32'hffffffff, 32'hf0000000,
                      512'h11, 1'b0, 1'b0, 128'h0, 1'b0, '0);
        applyStimulus(1'b1, 32'h98badcff, 32'h0, 32'hffffffff, 32'hf0000000,
                      512'h1234, 1'b0, 1'b0, 128'h0, 1'b1, 48'd1);
        idleCycles(2);
        checkOutput("wrap_found", found, 1);
        checkOutput("wrap_count", checked_count, 2);
        checkOutput("wrap_msg", match_msg, 512'h1234);
        ackPulse();
        checkOutput("wrap_ack_found", found, 0);

        // Re-arm in ARMED on the same edge as a matching candidate.
        armWith(T_IV);
        missCand(5);
        idleCycles(1);
        checkOutput("rearm_pre_count", checked_count, 5);
        applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 512'hC7, 1'b1, 1'b0, T_IV, 1'b0, '0);
        idleCycles(2);
        checkOutput("rearm_count", checked_count, 0);
        checkOutput("rearm_busy", busy, 1);
        checkOutput("rearm_found", found, 0);
        applyStimulus(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 512'hD8, 1'b0, 1'b0, 128'h0, 1'b1, 48'd0);
        idleCycles(2);
        checkOutput("rearm_hit_found", found, 1);
        checkOutput("rearm_hit_count", checked_count, 1);
        checkOutput("rearm_hit_index", match_index, 0);
        ackPulse();
        idleCycles(1);

        // Saturation of the narrow counter.
        armWith(T_IV);
        missCand(20);
        idleCycles(2);
        checkOutput("sat_count", sat_count, 15);
        checkOutput("sat_busy", sat_busy, 1);
        checkOutput("wide_count", checked_count, 20);
        missCand(3);
        idleCycles(2);
        checkOutput("sat_count_hold", sat_count, 15);
        checkOutput("wide_count_more", checked_count, 23);

        checkOutput("sb_drained", sb_queue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/md5_digest_checker.md
# md5_digest_checker

Terminal stage of the hash-breaker pipeline. It consumes the state words and message block emitted by the last MD5 round stage, adds the MD5 initial values to form the final digest, and compares that digest against a host-loaded target. It counts the candidates it checks and, on the first match, latches the winning 512-bit message and its index. It then holds them for the host until they are acknowledged.

## Interface
- CNT_W, 48, width of the candidate counter and match index
- clk  in  1  sole clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle request: load target, clear count, start searching
- target  in  128  digest to find, word form {A,B,C,D} (A in [127:96]); sampled only on arm
- in_valid  in  1  a_in..m_in carry a finished 64-round candidate this cycle
- a_in, b_in, c_in, d_in  in  32 each  final round state words, before IV addition
- m_in  in  512  message block belonging to the candidate
- ack  in  1  host has read the result; release FOUND
- busy  out  1  high in ARMED
- found  out  1  high in FOUND
- match_msg  out  512  message of the matching candidate
- match_index  out  CNT_W  0-based index of the matching candidate since the last arm
- checked_count  out  CNT_W  candidates compared since the last arm

## Operation
- States: IDLE, ARMED, FOUND. Reset and power-up go to IDLE.
- Stage 1 (registered): s_valid <= in_valid; sA = a_in+0x67452301, sB = b_in+0xefcdab89, sC = c_in+0x98badcfe, sD = d_in+0x10325476, each modulo 2^32 with carry discarded; s_msg <= m_in. Stage 1 runs in every state.
- Stage 2 (combinational on the stage-1 registers): hit = s_valid & ({sA,sB,sC,sD} == target_reg).
- **IDLE:**
  - arm: target_reg <= target, checked_count <= 0, s_valid <= 0, go to ARMED.
  - Stage-1 entries are otherwise ignored and are not counted.
- **ARMED:**
  - On each s_valid, checked_count increments, saturating at all-ones.
  - On hit: match_msg <= s_msg, match_index <= checked_count (pre-increment value), go to FOUND. The matching candidate is itself counted.
  - arm in ARMED re-arms: reload target, clear count, discard stage 1 (s_valid <= 0). Stay in ARMED.
- **FOUND:**
  - checked_count, match_msg and match_index are frozen, and candidates are ignored.
  - ack: go to IDLE; match_msg and match_index are retained.
  - arm is ignored. arm and ack in the same cycle: ack wins and the block ends in IDLE.
- ack outside FOUND is ignored.
- Only the first match after arm is reported. Later matches are lost until the block is re-armed.

## Timing
- All outputs reset to 0; state = IDLE; target_reg = 0; s_valid = 0.
- Back-to-back in_valid is accepted at 1 candidate per cycle. There is no backpressure; the upstream pipeline never stalls.
- Match latency: a candidate sampled at edge E0 sets found and loads match_msg and match_index at edge E0+1. found is visible in the cycle after E0+1.
- Count latency: checked_count reflects a candidate sampled at E0 after edge E0+1.
- A candidate sampled on the same edge as arm is discarded, as is any candidate already in stage 1.
- busy and found are mutually exclusive; both are low in IDLE.
- rst asserted mid-search: all state clears immediately, without waiting for clk; operation resumes on the first edge after release.

## Test plan
- **Reset:** rst pulse mid-ARMED with in_valid toggling → all outputs 0 immediately, state IDLE; candidates after release are not counted until arm.
- **IV-only match:** arm with target = {67452301,efcdab89,98badcfe,10325476}, then 3 candidates: a..d = 1 (miss), a..d = 0 with m = 512'hA5 (hit), a..d = 0 with m = 512'hB6 (hit).
  - found asserts 2 edges after the first zero-input candidate.
  - match_msg = 512'hA5, match_index = 1, checked_count = 2 and held.
- **Wrap arithmetic:** target A = 0x00000000; a_in = 0x98BADCFF, other words chosen to match → hit, confirming modulo-2^32 addition with carry dropped.
- **Re-arm:** arm in ARMED after 5 candidates, on the same edge as a matching candidate → that candidate is discarded, checked_count = 0, busy stays 1.
- **Handshake:**
  - In FOUND, pulse arm alone → ignored.
  - Then arm+ack together → IDLE; match_msg is retained and found = 0.
  - Next arm → ARMED with count 0.
- **Saturation:** CNT_W = 4, 20 consecutive non-matching candidates → checked_count = 15 and holds.
